// File: rtl/iter_counter.sv
// Iteration counter for the MDU sequencer: start/busy/done control FSM,
// programmable step, run-time latched configuration, exact clamp to the
// threshold on overshoot and optional auto-reload with a saturating hit count.
module iter_counter #(
  parameter int WIDTH     = 6,
  parameter int RLD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     startValue,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [WIDTH-1:0]     stepSize,
  input  logic                 upDown_n,
  input  logic                 autoReload,
  input  logic                 cnt_en,
  output logic [WIDTH-1:0]     countOut,
  output logic                 busy,
  output logic                 done,
  output logic                 terminalCount,
  output logic [RLD_WIDTH-1:0] reloadCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     count_q;
  logic [WIDTH-1:0]     sv_q, thr_q, step_q;
  logic                 up_q, ar_q;
  logic                 tc_q;
  logic [RLD_WIDTH-1:0] rc_q;

  logic [WIDTH:0]       nxt;
  logic                 hit;
  logic                 advance;

  localparam logic [RLD_WIDTH-1:0] RC_ONE = {{(RLD_WIDTH-1){1'b0}}, 1'b1};

  // Candidate next count in WIDTH+1 bits so carry/borrow take part in the hit test
  always_comb begin
    nxt = '0;
    hit = 1'b0;
    if (up_q) begin
      nxt = {1'b0, count_q} + {1'b0, step_q};
      hit = (nxt >= {1'b0, thr_q});
    end else begin
      nxt = {1'b0, count_q} - {1'b0, step_q};
      hit = nxt[WIDTH] || (nxt <= {1'b0, thr_q});
    end
  end

  assign advance = (state == S_RUN) && cnt_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: clear beats start beats counting; a non-reloading hit ends the run
  always_comb begin
    state_nxt = state;
    if (clear)                          state_nxt = S_IDLE;
    else if (start)                     state_nxt = S_RUN;
    else if (advance && hit && !ar_q)   state_nxt = S_DONE;
  end

  // Outputs are plain decodes of the registered state
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Count, config latch, terminal pulse and reload counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sv_q    <= '0;
      thr_q   <= '0;
      step_q  <= '0;
      up_q    <= 1'b0;
      ar_q    <= 1'b0;
      tc_q    <= 1'b0;
      rc_q    <= '0;
    end else if (clear) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (start) begin
      sv_q    <= startValue;
      thr_q   <= threshold;
      step_q  <= stepSize;
      up_q    <= upDown_n;
      ar_q    <= autoReload;
      count_q <= startValue;
      rc_q    <= '0;
      tc_q    <= 1'b0;
    end else if (advance) begin
      tc_q <= hit;
      if (!hit) begin
        count_q <= nxt[WIDTH-1:0];
      end else if (ar_q) begin
        count_q <= sv_q;
        if (rc_q != '1) rc_q <= rc_q + RC_ONE;
      end else begin
        count_q <= thr_q;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign countOut      = count_q;
  assign terminalCount = tc_q;
  assign reloadCount   = rc_q;

endmodule
